// File: rtl/instr_trace_checker_if.sv
// ----------------------------------------------------------------------------
// instr_trace_checker_if
//   Bundles the control, load, decode-observation and result signals of the
//   instruction trace checker. Clock and reset stay outside the interface.
//
//   master : the side that drives stimulus (debug wrapper / testbench)
//   slave  : the checker itself
//
//   clear           m->s  sync flush back to IDLE
//   load_valid      m->s  expected-entry write request
//   load_instr      m->s  expected instruction
//   load_ready      s->m  entry accepted when load_valid && load_ready
//   enable          m->s  arm the checker
//   trigger         m->s  start comparison
//   test_undone     m->s  high while the test is still running
//   cycle_count     m->s  free-running cycle stamp
//   dec_valid       m->s  decode-stage instruction valid
//   dec_instr       m->s  decode-stage instruction
//   busy            s->m  ARMED or RUN
//   pass / fail     s->m  sticky verdict
//   timeout         s->m  no trigger arrived in time
//   underrun        s->m  test ended before the trace was consumed
//   mismatch_cnt    s->m  number of mismatching compares
//   first_err_*     s->m  index / cycle / expected / observed of first mismatch
// ----------------------------------------------------------------------------
interface instr_trace_checker_if #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 64,
    parameter int CYCLE_CNT_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   clear;
    logic                   load_valid;
    logic [XLEN-1:0]        load_instr;
    logic                   load_ready;
    logic                   enable;
    logic                   trigger;
    logic                   test_undone;
    logic [CYCLE_CNT_W-1:0] cycle_count;
    logic                   dec_valid;
    logic [XLEN-1:0]        dec_instr;
    logic                   busy;
    logic                   pass;
    logic                   fail;
    logic                   timeout;
    logic                   underrun;
    logic [CNT_W-1:0]       mismatch_cnt;
    logic [CNT_W-2:0]       first_err_idx;
    logic [CYCLE_CNT_W-1:0] first_err_cycle;
    logic [XLEN-1:0]        first_err_exp;
    logic [XLEN-1:0]        first_err_got;

    modport master (
        output clear, load_valid, load_instr, enable, trigger, test_undone,
               cycle_count, dec_valid, dec_instr,
        input  load_ready, busy, pass, fail, timeout, underrun, mismatch_cnt,
               first_err_idx, first_err_cycle, first_err_exp, first_err_got
    );

    modport slave (
        input  clear, load_valid, load_instr, enable, trigger, test_undone,
               cycle_count, dec_valid, dec_instr,
        output load_ready, busy, pass, fail, timeout, underrun, mismatch_cnt,
               first_err_idx, first_err_cycle, first_err_exp, first_err_got
    );
endinterface

// File: rtl/instr_trace_checker.sv
// ----------------------------------------------------------------------------
// instr_trace_checker
//   Holds an expected instruction trace loaded while IDLE, then compares the
//   live decode-stage stream against it entry by entry and reports a sticky
//   pass/fail verdict plus details of the first mismatch.
//
//   clk   : core clock
//   rstn  : asynchronous active-low reset
//   bus   : instr_trace_checker_if.slave (load, control, decode, results)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | accept expected entries; wait for enable
//   ARMED | wait for trigger; watchdog runs, expiry -> FAIL with timeout
//   RUN   | compare each valid decode instruction against the trace
//   PASS  | every entry matched; held until clear
//   FAIL  | mismatch, timeout or underrun; held until clear
// ----------------------------------------------------------------------------
module instr_trace_checker #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 64,
    parameter int CYCLE_CNT_W = 32,
    parameter int WDOG_CYC    = 1000
) (
    input  logic                 clk,
    input  logic                 rstn,
    instr_trace_checker_if.slave bus
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W  = CNT_W - 1;
    localparam int WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    // Watchdog is a down-counter: loaded on ARMED entry, terminal count at 0.
    // Reaching 0 without trigger equals WDOG_CYC-1 elapsed ARMED cycles.
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYC - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_PASS  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       exp_cnt_q, exp_cnt_d;
    logic [IDX_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [WDOG_W-1:0]      wdog_q, wdog_d;
    logic                   timeout_q, timeout_d;
    logic                   underrun_q, underrun_d;
    logic [CNT_W-1:0]       mis_cnt_q, mis_cnt_d;
    logic [IDX_W-1:0]       ferr_idx_q, ferr_idx_d;
    logic [CYCLE_CNT_W-1:0] ferr_cyc_q, ferr_cyc_d;
    logic [XLEN-1:0]        ferr_exp_q, ferr_exp_d;
    logic [XLEN-1:0]        ferr_got_q, ferr_got_d;

    // Trace storage is deliberately not reset; validity is tracked by exp_cnt.
    logic [XLEN-1:0]        mem [DEPTH];

    logic                   load_ready;
    logic                   load_fire;
    logic                   mem_we;
    logic [XLEN-1:0]        rd_data;
    logic                   cmp_fire;
    logic                   cmp_mismatch;
    logic                   cmp_last;

    assign load_ready   = (state_q == S_IDLE) && (exp_cnt_q < DEPTH_C);
    assign load_fire    = bus.load_valid && load_ready;
    assign mem_we       = load_fire && !bus.clear;

    assign rd_data      = mem[rd_ptr_q];
    assign cmp_fire     = (state_q == S_RUN) && bus.dec_valid;
    assign cmp_mismatch = cmp_fire && (bus.dec_instr != rd_data);
    // exp_cnt is at least 1 whenever RUN is reachable, so the subtract is safe.
    assign cmp_last     = cmp_fire && ({1'b0, rd_ptr_q} == (exp_cnt_q - ONE_C));

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[exp_cnt_q[IDX_W-1:0]] <= bus.load_instr;
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_cnt_d  = exp_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wdog_d     = wdog_q;
        timeout_d  = timeout_q;
        underrun_d = underrun_q;
        mis_cnt_d  = mis_cnt_q;
        ferr_idx_d = ferr_idx_q;
        ferr_cyc_d = ferr_cyc_q;
        ferr_exp_d = ferr_exp_q;
        ferr_got_d = ferr_got_q;

        if (bus.clear) begin
            state_d    = S_IDLE;
            exp_cnt_d  = '0;
            rd_ptr_d   = '0;
            wdog_d     = '0;
            timeout_d  = 1'b0;
            underrun_d = 1'b0;
            mis_cnt_d  = '0;
            ferr_idx_d = '0;
            ferr_cyc_d = '0;
            ferr_exp_d = '0;
            ferr_got_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_fire) begin
                        exp_cnt_d = exp_cnt_q + ONE_C;
                    end
                    // A load accepted in the enable cycle already counts here.
                    if (bus.enable) begin
                        if (exp_cnt_d == '0) begin
                            state_d = S_PASS;
                        end else begin
                            state_d = S_ARMED;
                            wdog_d  = WDOG_LOAD;
                        end
                    end
                end

                S_ARMED: begin
                    if (bus.trigger) begin
                        state_d = S_RUN;
                        wdog_d  = WDOG_LOAD;
                    end else if (wdog_q == '0) begin
                        state_d   = S_FAIL;
                        timeout_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q - 1'b1;
                    end
                end

                S_RUN: begin
                    if (cmp_fire) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        if (cmp_mismatch) begin
                            mis_cnt_d = mis_cnt_q + ONE_C;
                            if (mis_cnt_q == '0) begin
                                ferr_idx_d = rd_ptr_q;
                                ferr_cyc_d = bus.cycle_count;
                                ferr_exp_d = rd_data;
                                ferr_got_d = bus.dec_instr;
                            end
                        end
                    end
                    // The final compare takes precedence over test_undone falling.
                    if (cmp_last) begin
                        if ((mis_cnt_q == '0) && !cmp_mismatch) begin
                            state_d = S_PASS;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end else if (!bus.test_undone) begin
                        state_d    = S_FAIL;
                        underrun_d = 1'b1;
                    end
                end

                S_PASS, S_FAIL: begin
                    state_d = state_q;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            exp_cnt_q  <= '0;
            rd_ptr_q   <= '0;
            wdog_q     <= '0;
            timeout_q  <= 1'b0;
            underrun_q <= 1'b0;
            mis_cnt_q  <= '0;
            ferr_idx_q <= '0;
            ferr_cyc_q <= '0;
            ferr_exp_q <= '0;
            ferr_got_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_cnt_q  <= exp_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wdog_q     <= wdog_d;
            timeout_q  <= timeout_d;
            underrun_q <= underrun_d;
            mis_cnt_q  <= mis_cnt_d;
            ferr_idx_q <= ferr_idx_d;
            ferr_cyc_q <= ferr_cyc_d;
            ferr_exp_q <= ferr_exp_d;
            ferr_got_q <= ferr_got_d;
        end
    end

    assign bus.load_ready      = load_ready;
    assign bus.busy            = (state_q == S_ARMED) || (state_q == S_RUN);
    assign bus.pass            = (state_q == S_PASS);
    assign bus.fail            = (state_q == S_FAIL);
    assign bus.timeout         = timeout_q;
    assign bus.underrun        = underrun_q;
    assign bus.mismatch_cnt    = mis_cnt_q;
    assign bus.first_err_idx   = ferr_idx_q;
    assign bus.first_err_cycle = ferr_cyc_q;
    assign bus.first_err_exp   = ferr_exp_q;
    assign bus.first_err_got   = ferr_got_q;

endmodule

// File: tb/tb_instr_trace_checker.sv
module tb_instr_trace_checker;

    localparam int XLEN        = 32;
    localparam int DEPTH       = 64;
    localparam int CYCLE_CNT_W = 32;
    localparam int WDOG_CYC    = 1000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    instr_trace_checker_if #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CYCLE_CNT_W(CYCLE_CNT_W)
    ) bus ();

    instr_trace_checker #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CYCLE_CNT_W(CYCLE_CNT_W), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard
    string       sb_tag [$];
    logic [63:0] sb_val [$];

    // reference model of the trace and the compare results
    logic [31:0] m_trace [DEPTH];
    int          m_cnt;
    int          m_rd;
    int          m_mis;
    logic [63:0] m_fidx, m_fcyc, m_fexp, m_fgot;

    logic [31:0] tr4 [4];

    task automatic m_reset();
        m_cnt = 0; m_rd = 0; m_mis = 0;
        m_fidx = '0; m_fcyc = '0; m_fexp = '0; m_fgot = '0;
    endtask

    task automatic m_load(input logic [31:0] w);
        if (m_cnt < DEPTH) begin
            m_trace[m_cnt] = w;
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        sb_tag.push_back(tag);
        sb_val.push_back(v);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        n_checks++;
        if (sb_val.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            t = sb_tag.pop_front();
            e = sb_val.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic push_all(input string step, input logic lr, input logic by,
                            input logic ps, input logic fl, input logic to,
                            input logic ur, input logic [63:0] mc,
                            input logic [63:0] idx, input logic [63:0] cyc,
                            input logic [63:0] ex, input logic [63:0] got);
        push({step, ".load_ready"}, {63'd0, lr});
        push({step, ".busy"},       {63'd0, by});
        push({step, ".pass"},       {63'd0, ps});
        push({step, ".fail"},       {63'd0, fl});
        push({step, ".timeout"},    {63'd0, to});
        push({step, ".underrun"},   {63'd0, ur});
        push({step, ".mismatch_cnt"},    mc);
        push({step, ".first_err_idx"},   idx);
        push({step, ".first_err_cycle"}, cyc);
        push({step, ".first_err_exp"},   ex);
        push({step, ".first_err_got"},   got);
    endtask

    task automatic check_all();
        pop_check({63'd0, bus.load_ready});
        pop_check({63'd0, bus.busy});
        pop_check({63'd0, bus.pass});
        pop_check({63'd0, bus.fail});
        pop_check({63'd0, bus.timeout});
        pop_check({63'd0, bus.underrun});
        pop_check(64'(bus.mismatch_cnt));
        pop_check(64'(bus.first_err_idx));
        pop_check(64'(bus.first_err_cycle));
        pop_check(64'(bus.first_err_exp));
        pop_check(64'(bus.first_err_got));
    endtask

    task automatic push_reset(input string step);
        push_all(step, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic push_verdict(input string step);
        push_all(step, 1'b0, 1'b0, (m_mis == 0), (m_mis != 0), 1'b0, 1'b0,
                 64'(m_mis), m_fidx, m_fcyc, m_fexp, m_fgot);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.cycle_count = bus.cycle_count + 1'b1;
    endtask

    task automatic ld(input logic [31:0] w);
        bus.load_valid = 1'b1;
        bus.load_instr = w;
        m_load(w);
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic en();
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic trig();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
    endtask

    task automatic dv(input logic [31:0] w);
        bus.dec_valid = 1'b1;
        bus.dec_instr = w;
        if (m_rd < m_cnt) begin
            if (w !== m_trace[m_rd]) begin
                if (m_mis == 0) begin
                    m_fidx = 64'(m_rd);
                    m_fcyc = 64'(bus.cycle_count);
                    m_fexp = 64'(m_trace[m_rd]);
                    m_fgot = 64'(w);
                end
                m_mis = m_mis + 1;
            end
            m_rd = m_rd + 1;
        end
        tick();
        bus.dec_valid = 1'b0;
    endtask

    task automatic clr();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        m_reset();
    endtask

    task automatic load4();
        for (int i = 0; i < 4; i++) ld(tr4[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        tr4[0] = 32'h0000_0013;
        tr4[1] = 32'h0050_0093;
        tr4[2] = 32'h0010_8133;
        tr4[3] = 32'h0000_006F;
        bus.clear       = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_instr  = '0;
        bus.enable      = 1'b0;
        bus.trigger     = 1'b0;
        bus.test_undone = 1'b1;
        bus.cycle_count = '0;
        bus.dec_valid   = 1'b0;
        bus.dec_instr   = '0;
        m_reset();

        // reset state
        repeat (2) tick();
        push_reset("reset");
        check_all();
        rstn = 1'b1;
        tick();

        // matching trace -> pass
        load4();
        en();
        push_all("armed", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        check_all();
        trig();
        for (int i = 0; i < 3; i++) dv(tr4[i]);
        push("pass_latency.pass", 64'd0);
        pop_check({63'd0, bus.pass});
        dv(tr4[3]);
        push_verdict("pass4");
        check_all();
        // PASS is sticky and ignores inputs
        bus.dec_valid = 1'b1; bus.dec_instr = 32'hDEAD_BEEF;
        bus.trigger = 1'b1; bus.enable = 1'b1;
        repeat (2) tick();
        bus.dec_valid = 1'b0; bus.trigger = 1'b0; bus.enable = 1'b0;
        push_verdict("pass_sticky");
        check_all();
        clr();
        push_reset("clear_pass");
        check_all();

        // mismatch at index 2 stamped at cycle 57; ARMED decode traffic ignored
        load4();
        en();
        bus.dec_valid = 1'b1; bus.dec_instr = 32'h1111_1111;
        tick();
        bus.trigger = 1'b1; bus.dec_instr = 32'h2222_2222;
        tick();
        bus.trigger = 1'b0; bus.dec_valid = 1'b0;
        dv(tr4[0]);
        tick();
        dv(tr4[1]);
        bus.cycle_count = 32'd57;
        dv(32'h0020_8133);
        dv(tr4[3]);
        push_verdict("mismatch");
        check_all();
        clr();
        push_reset("clear_fail");
        check_all();

        // enable with no entries -> immediate pass
        en();
        push_all("empty_en", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        check_all();
        clr();

        // load accepted in the enable cycle counts
        bus.load_valid = 1'b1; bus.load_instr = 32'h0000_0073; m_load(32'h0000_0073);
        bus.enable = 1'b1;
        tick();
        bus.load_valid = 1'b0; bus.enable = 1'b0;
        push("load_in_en.busy", 64'd1);
        pop_check({63'd0, bus.busy});
        trig();
        dv(32'h0000_0073);
        push_verdict("load_in_en");
        check_all();
        clr();

        // watchdog; trigger in the enable cycle must be ignored
        ld(32'h0000_0013);
        bus.enable = 1'b1; bus.trigger = 1'b1;
        tick();
        bus.enable = 1'b0; bus.trigger = 1'b0;
        repeat (WDOG_CYC - 1) tick();
        push_all("wdog_pre", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        check_all();
        tick();
        push_all("wdog_exp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0);
        check_all();
        clr();

        // overflow: DEPTH+2 back-to-back loads, only DEPTH kept
        bus.load_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus.load_instr = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
            if (i == DEPTH - 1) begin
                push("ovf_ready_last", 64'd1);
                pop_check({63'd0, bus.load_ready});
            end
            if (i == DEPTH) begin
                push("ovf_ready_full", 64'd0);
                pop_check({63'd0, bus.load_ready});
            end
            if (bus.load_ready) m_load(bus.load_instr);
            tick();
        end
        bus.load_valid = 1'b0;
        en();
        trig();
        for (int i = 0; i < DEPTH - 1; i++) dv(m_trace[i]);
        push("ovf_pre.busy", 64'd1);
        pop_check({63'd0, bus.busy});
        dv(m_trace[DEPTH-1]);
        push_verdict("ovf");
        check_all();
        clr();

        // underrun after 2 of 4
        load4();
        en();
        trig();
        dv(tr4[0]);
        dv(tr4[1]);
        bus.test_undone = 1'b0;
        tick();
        bus.test_undone = 1'b1;
        push_all("underrun", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0);
        check_all();
        clr();

        // test_undone falls on the last compare: compare wins
        load4();
        en();
        trig();
        for (int i = 0; i < 3; i++) dv(tr4[i]);
        bus.test_undone = 1'b0;
        dv(tr4[3]);
        bus.test_undone = 1'b1;
        push_verdict("undone_last");
        check_all();
        clr();

        // async reset mid-RUN
        load4();
        en();
        trig();
        dv(32'h1234_5678);
        #2 rstn = 1'b0;
        #1;
        m_reset();
        push_reset("reset_midrun");
        check_all();
        #1 rstn = 1'b1;
        tick();

        // reach FAIL again, then clear
        ld(32'h0000_0013);
        en();
        trig();
        dv(32'h0000_0093);
        push_verdict("fail_after_reset");
        check_all();
        clr();
        push_reset("clear_after_reset");
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
